// File: rtl/rriot_pkg.sv
// Shared definitions for the RRIOT interval-timer bus initiator.
// Holds the initiator state enum and the timer register address codes.
package rriot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_ADDR,
    ST_READ_WAIT,
    ST_RESP,
    ST_RELOAD
  } rriot_init_state_t;

  // A[2] selects the irq enable on timer writes.
  localparam int RRIOT_A_IRQEN_BIT = 2;

  // A[1:0] divider select codes on timer writes.
  localparam logic [1:0] RRIOT_DIV_1    = 2'b00;
  localparam logic [1:0] RRIOT_DIV_8    = 2'b01;
  localparam logic [1:0] RRIOT_DIV_64   = 2'b10;
  localparam logic [1:0] RRIOT_DIV_1024 = 2'b11;

  // Status read with A[0]=1: reading it has no side effects.
  localparam logic [2:0] RRIOT_IDLE_ADDR = 3'b101;

endpackage

// File: rtl/rriot_bus_initiator.sv
// Bus initiator for the RRIOT timer register window: turns a
// valid/ready command stream into single-cycle peripheral bus cycles.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   host command handshake
//   cmd_write/addr/   command kind, register address, write data
//   cmd_wdata
//   rsp_valid/rdata   one-cycle read response pulse and data
//   reload_addr/val   auto-reload write target and data
//   bus_we_n/a/wdata  registered peripheral bus outputs
//   bus_rdata         peripheral read data (registered in the timer)
//   bus_irq_n         timer irq, active-low, may be a 1-cycle pulse
//   irq_pending       sticky irq flag, irq_clr clears it
module rriot_bus_initiator
  import rriot_pkg::*;
#(
  parameter int         READ_LAT    = 1,
  parameter bit         AUTO_RELOAD = 1'b0,
  parameter logic [2:0] IDLE_ADDR   = RRIOT_IDLE_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [2:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  input  logic [2:0] reload_addr,
  input  logic [7:0] reload_val,
  output logic       bus_we_n,
  output logic [2:0] bus_a,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       bus_irq_n,
  output logic       irq_pending,
  input  logic       irq_clr
);

  localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

  rriot_init_state_t state_q;
  logic [1:0] cnt_q;
  logic       cmd_ready_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_rdata_q;
  logic       bus_we_n_q;
  logic [2:0] bus_a_q;
  logic [7:0] bus_wdata_q;
  logic       irq_pending_q;
  logic       irq_pending_d;
  logic       irq_n_q;
  logic       reload_req_q;
  logic       reload_req_d;
  logic       irq_fall;

  // Set wins over clear so a pulse coinciding with irq_clr
  // is never lost. A fresh falling sample during RELOAD re-arms
  // the request after the current reload retires it.
  always_comb begin
    irq_fall      = irq_n_q & ~bus_irq_n;
    irq_pending_d = ~bus_irq_n | (irq_pending_q & ~irq_clr);
    reload_req_d  = reload_req_q;
    if (state_q == ST_RELOAD) reload_req_d = 1'b0;
    if (AUTO_RELOAD && irq_fall) reload_req_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 2'd0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 8'h00;
      bus_we_n_q    <= 1'b1;
      bus_a_q       <= IDLE_ADDR;
      bus_wdata_q   <= 8'h00;
      irq_pending_q <= 1'b0;
      irq_n_q       <= 1'b1;
      reload_req_q  <= 1'b0;
    end else begin
      irq_n_q       <= bus_irq_n;
      irq_pending_q <= irq_pending_d;
      reload_req_q  <= reload_req_d;
      rsp_valid_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (reload_req_q) begin
            state_q     <= ST_RELOAD;
            bus_we_n_q  <= 1'b0;
            bus_a_q     <= reload_addr;
            bus_wdata_q <= reload_val;
            cmd_ready_q <= 1'b0;
          end else if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            bus_a_q     <= cmd_addr;
            if (cmd_write) begin
              state_q     <= ST_WRITE;
              bus_we_n_q  <= 1'b0;
              bus_wdata_q <= cmd_wdata;
            end else begin
              state_q <= ST_READ_ADDR;
              cnt_q   <= LAT_M1;
            end
          end else begin
            cmd_ready_q <= ~reload_req_d;
          end
        end
        ST_WRITE, ST_RELOAD: begin
          state_q     <= ST_IDLE;
          bus_we_n_q  <= 1'b1;
          bus_a_q     <= IDLE_ADDR;
          cmd_ready_q <= ~reload_req_d;
        end
        // Address stays on the bus until the peripheral's
        // registered data is ready to be captured in RESP.
        ST_READ_ADDR, ST_READ_WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q <= ST_RESP;
            bus_a_q <= IDLE_ADDR;
          end else begin
            state_q <= ST_READ_WAIT;
            cnt_q   <= cnt_q - 2'd1;
          end
        end
        ST_RESP: begin
          rsp_rdata_q <= bus_rdata;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_IDLE;
          cmd_ready_q <= ~reload_req_d;
        end
        default: begin
          state_q     <= ST_IDLE;
          bus_we_n_q  <= 1'b1;
          bus_a_q     <= IDLE_ADDR;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign bus_we_n    = bus_we_n_q;
  assign bus_a       = bus_a_q;
  assign bus_wdata   = bus_wdata_q;
  assign irq_pending = irq_pending_q;

endmodule

// File: tb/tb_rriot_bus_initiator.sv
// Self-checking bench for rriot_bus_initiator (READ_LAT=2, AUTO_RELOAD=1).
// Directed table, corner sequences and random traffic against a model.
module tb_rriot_bus_initiator;

  localparam int         L    = 2;
  localparam logic [2:0] RL_A = 3'b101;
  localparam logic [7:0] RL_D = 8'h20;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [2:0] reload_addr;
  logic [7:0] reload_val;
  logic       bus_we_n;
  logic [2:0] bus_a;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata = 8'h00;
  logic       bus_irq_n;
  logic       irq_pending;
  logic       irq_clr;

  rriot_bus_initiator #(
    .READ_LAT(L), .AUTO_RELOAD(1'b1), .IDLE_ADDR(3'b101)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .reload_addr(reload_addr), .reload_val(reload_val),
    .bus_we_n(bus_we_n), .bus_a(bus_a),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_irq_n(bus_irq_n), .irq_pending(irq_pending),
    .irq_clr(irq_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral: register file with registered data out.
  logic [7:0] mem [8] = '{default: 8'h00};
  always @(posedge clk) begin
    if (!bus_we_n) mem[bus_a] <= bus_wdata;
    bus_rdata <= mem[bus_a];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Transaction-level reference model.
  typedef struct { logic [2:0] a; logic [7:0] d; } wr_t;
  typedef struct { int due; logic [7:0] d; } rd_t;
  wr_t        exp_wr[$];
  rd_t        exp_rd[$];
  logic [7:0] model_mem [8] = '{default: 8'h00};
  int         reload_due = 0;
  logic       prev_irq_n = 1'b1;
  logic       exp_pend = 1'b0;

  always @(posedge clk)
    if (rst) exp_pend <= 1'b0;
    else     exp_pend <= !bus_irq_n ? 1'b1 : (irq_clr ? 1'b0 : exp_pend);

  always @(negedge clk) begin
    wr_t w;
    rd_t r;
    if (rst) begin
      exp_wr.delete();
      exp_rd.delete();
      reload_due = 0;
      prev_irq_n = 1'b1;
    end else begin
      if (cmd_valid && cmd_ready) begin
        if (cmd_write) begin
          w.a = cmd_addr;
          w.d = cmd_wdata;
          exp_wr.push_back(w);
          model_mem[cmd_addr] = cmd_wdata;
        end else begin
          r.due = cyc + L + 2;
          r.d   = model_mem[cmd_addr];
          exp_rd.push_back(r);
        end
      end
      if (prev_irq_n && !bus_irq_n) reload_due++;
      prev_irq_n = bus_irq_n;
      chk("irq_pending", irq_pending, exp_pend);
      if (!bus_we_n) begin
        if (reload_due > 0 && bus_a == RL_A && bus_wdata == RL_D) begin
          reload_due--;
          model_mem[RL_A] = RL_D;
          total++;
        end else if (exp_wr.size() > 0) begin
          chk("bus_wr_addr", bus_a, exp_wr[0].a);
          chk("bus_wr_data", bus_wdata, exp_wr[0].d);
          void'(exp_wr.pop_front());
        end else begin
          total++;
          bad++;
          $display("FAIL bus_wr_unexpected: got a=%0h d=%0h want none",
                   bus_a, bus_wdata);
        end
      end
      if (rsp_valid) begin
        if (exp_rd.size() > 0) begin
          chk("rsp_cycle", cyc, exp_rd[0].due);
          chk("rsp_data", rsp_rdata, exp_rd[0].d);
          void'(exp_rd.pop_front());
        end else begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 want 0");
        end
      end else if (exp_rd.size() > 0 && exp_rd[0].due <= cyc) begin
        total++;
        bad++;
        $display("FAIL rsp_missing: got none want rsp at cycle %0d",
                 exp_rd[0].due);
        void'(exp_rd.pop_front());
      end
    end
  end

  bit rnd_irq = 1'b0;
  int since   = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_irq) begin
      irq_clr = ($urandom_range(0, 7) == 0);
      if (!bus_irq_n) bus_irq_n = 1'b1;
      else if (since >= 12 && $urandom_range(0, 5) == 0) begin
        bus_irq_n = 1'b0;
        since = 0;
      end
      since++;
    end
  endtask

  task automatic do_cmd(input bit w, input logic [2:0] a,
                        input logic [7:0] d);
    bit ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int i = 0; i < 30; i++) begin
      if (cmd_ready) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL cmd_accept: got timeout want handshake");
    end
  endtask

  typedef struct {
    bit         w;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[9];
    logic [10:0] got[$];
    int n, hits;
    bit hs;
    logic [2:0] ra;

    vt[0] = '{1'b1, 3'b000, 8'h11, 8'h00};
    vt[1] = '{1'b1, 3'b011, 8'h5A, 8'h00};
    vt[2] = '{1'b1, 3'b110, 8'hC3, 8'h00};
    vt[3] = '{1'b0, 3'b011, 8'h00, 8'h5A};
    vt[4] = '{1'b0, 3'b000, 8'h00, 8'h11};
    vt[5] = '{1'b1, 3'b011, 8'hA5, 8'h00};
    vt[6] = '{1'b0, 3'b011, 8'h00, 8'hA5};
    vt[7] = '{1'b0, 3'b111, 8'h00, 8'h10};
    vt[8] = '{1'b0, 3'b110, 8'h00, 8'hC3};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = 3'b000;
    cmd_wdata = 8'h00;
    bus_irq_n = 1'b1;
    irq_clr = 1'b0;
    reload_addr = RL_A;
    reload_val = RL_D;

    repeat (3) step();
    chk("rst_we_n", bus_we_n, 1'b1);
    chk("rst_bus_a", bus_a, 3'b101);
    chk("rst_wdata", bus_wdata, 8'h00);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_irq_pending", irq_pending, 1'b0);
    rst = 1'b0;
    step();
    step();

    do_cmd(1'b1, 3'b111, 8'h10);
    chk("wr_we_n", bus_we_n, 1'b0);
    chk("wr_bus_a", bus_a, 3'b111);
    chk("wr_wdata", bus_wdata, 8'h10);
    chk("wr_cmd_ready", cmd_ready, 1'b0);
    step();
    chk("wr_end_we_n", bus_we_n, 1'b1);
    chk("wr_end_bus_a", bus_a, 3'b101);

    for (int i = 0; i < 9; i++) begin
      do_cmd(vt[i].w, vt[i].a, vt[i].d);
      if (!vt[i].w) begin
        n = 1;
        while (!rsp_valid && n < 10) begin
          step();
          n++;
        end
        chk("tbl_rd_latency", n, L + 2);
        chk("tbl_rd_data", rsp_rdata, vt[i].exp);
        step();
        chk("tbl_rsp_pulse", rsp_valid, 1'b0);
      end
    end

    bus_irq_n = 1'b0;
    step();
    bus_irq_n = 1'b1;
    chk("irq_set", irq_pending, 1'b1);
    repeat (3) step();
    chk("irq_sticky", irq_pending, 1'b1);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("irq_clear", irq_pending, 1'b0);
    bus_irq_n = 1'b0;
    irq_clr = 1'b1;
    step();
    bus_irq_n = 1'b1;
    irq_clr = 1'b0;
    chk("irq_set_wins", irq_pending, 1'b1);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    repeat (4) step();

    do_cmd(1'b1, 3'b000, 8'h33);
    if (!bus_we_n) got.push_back({bus_a, bus_wdata});
    bus_irq_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 3'b010;
    cmd_wdata = 8'h44;
    for (int i = 0; i < 12; i++) begin
      hs = cmd_valid && cmd_ready;
      step();
      bus_irq_n = 1'b1;
      if (hs) cmd_valid = 1'b0;
      if (!bus_we_n) got.push_back({bus_a, bus_wdata});
    end
    cmd_valid = 1'b0;
    chk("reload_nwrites", got.size(), 3);
    if (got.size() == 3) begin
      chk("reload_order0", got[0], {3'b000, 8'h33});
      chk("reload_order1", got[1], {RL_A, RL_D});
      chk("reload_order2", got[2], {3'b010, 8'h44});
    end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;

    bus_irq_n = 1'b0;
    step();
    bus_irq_n = 1'b1;
    repeat (4) step();
    do_cmd(1'b0, 3'b011, 8'h00);
    step();
    rst = 1'b1;
    repeat (3) step();
    chk("midrd_rst_we_n", bus_we_n, 1'b1);
    chk("midrd_rst_bus_a", bus_a, 3'b101);
    chk("midrd_rst_pend", irq_pending, 1'b0);
    chk("midrd_rst_rsp", rsp_valid, 1'b0);
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid) hits++;
    end
    chk("midrd_no_rsp", hits, 0);

    hits = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus_a !== 3'b101 || bus_we_n !== 1'b1) hits++;
    end
    chk("idle_bus_stable", hits, 0);

    rnd_irq = 1'b1;
    since = 0;
    for (int i = 0; i < 300; i++) begin
      ra = 3'($urandom_range(0, 6));
      if (ra >= 3'd5) ra = ra + 3'd1;
      do_cmd(1'($urandom_range(0, 1)), ra, 8'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end
    rnd_irq = 1'b0;
    irq_clr = 1'b0;
    bus_irq_n = 1'b1;
    repeat (20) step();
    chk("end_wr_drained", exp_wr.size(), 0);
    chk("end_rd_drained", exp_rd.size(), 0);
    chk("end_reloads_done", reload_due, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
